// File: rtl/shift_arbiter_if.sv
// Request/response bundle between two requesters and one shift-result consumer.
// The slave modport is the arbiter side and the master modport is the environment side.
interface shift_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [9:0]  req_shamt;
    logic [3:0]  req_typ;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_r;
    logic        resp_id;

    modport slave (
        input  req_valid, req_a, req_shamt, req_typ, resp_ready,
        output req_ready, resp_valid, resp_r, resp_id
    );

    modport master (
        output req_valid, req_a, req_shamt, req_typ, resp_ready,
        input  req_ready, resp_valid, resp_r, resp_id
    );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter that feeds a 32-bit shifter into a single
// registered response slot, sustaining one result per clock.
module shift_arbiter #(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    shift_arbiter_if.slave    bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      state_r;
    logic [0:0]      state_nxt_s;
    logic            prio_r;
    logic [31:0]     resp_r_r;
    logic            resp_id_r;
    logic [NREQ-1:0] grant_s;
    logic [NREQ-1:0] ready_s;
    logic            can_accept_s;
    logic            accept_s;
    logic            gnt_id_s;
    logic [31:0]     sel_a_s;
    logic [4:0]      sel_shamt_s;
    logic [1:0]      sel_typ_s;
    logic [31:0]     result_s;

    function automatic logic [31:0] shift_op(input logic [31:0] a,
                                             input logic [4:0]  sh,
                                             input logic [1:0]  typ);
        case (typ)
            2'b00:   shift_op = a << sh;
            2'b01:   shift_op = a >> sh;
            2'b10:   shift_op = $unsigned($signed(a) >>> sh);
            2'b11:   shift_op = {16'h0000, a[31:16]};
            default: shift_op = a;
        endcase
    endfunction

    // Round-robin grant: prio only matters when both requesters are valid.
    always_comb begin
        grant_s = {NREQ{1'b0}};
        case (bus.req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = prio_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    // Ready is withheld during reset so nothing presented then is consumed.
    always_comb begin
        can_accept_s = (state_r == ST_EMPTY) || bus.resp_ready;
        if (can_accept_s && !rst) begin
            ready_s = grant_s;
        end else begin
            ready_s = 2'b00;
        end
        accept_s  = |(ready_s & bus.req_valid);
        gnt_id_s  = grant_s[1];
        bus.req_ready = ready_s;
    end

    // Operand mux for the granted requester and the shift itself.
    always_comb begin
        if (gnt_id_s) begin
            sel_a_s     = bus.req_a[63:32];
            sel_shamt_s = bus.req_shamt[9:5];
            sel_typ_s   = bus.req_typ[3:2];
        end else begin
            sel_a_s     = bus.req_a[31:0];
            sel_shamt_s = bus.req_shamt[4:0];
            sel_typ_s   = bus.req_typ[1:0];
        end
        result_s = shift_op(sel_a_s, sel_shamt_s, sel_typ_s);
    end

    // Output slot next-state: accept wins over drain, so accept+drain stays FULL.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else if (bus.resp_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Slot, result and priority registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_EMPTY;
            prio_r    <= 1'b0;
            resp_r_r  <= 32'h0000_0000;
            resp_id_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                resp_r_r  <= result_s;
                resp_id_r <= gnt_id_s;
                prio_r    <= ~gnt_id_s;
            end
        end
    end

    // Response outputs come straight from registers.
    always_comb begin
        bus.resp_valid = (state_r == ST_FULL);
        bus.resp_r     = resp_r_r;
        bus.resp_id    = resp_id_r;
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed vector bench for shift_arbiter: one table row per clock, outputs
// sampled on the falling edge, plus a hand-written sustained-throughput run.
module tb_shift_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    shift_arbiter_if bus ();

    shift_arbiter #(.NREQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rs;
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [4:0]  s0;
        logic [1:0]  t0;
        logic [31:0] a1;
        logic [4:0]  s1;
        logic [1:0]  t1;
        logic        rr;
        logic [1:0]  e_ready;
        logic        e_v;
        logic [31:0] e_r;
        logic        e_id;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rs, logic [1:0] valid,
                                logic [31:0] a0, logic [4:0] s0, logic [1:0] t0,
                                logic [31:0] a1, logic [4:0] s1, logic [1:0] t1,
                                logic rr, logic [1:0] e_ready, logic e_v,
                                logic [31:0] e_r, logic e_id);
        vec_t v;
        v.rs = rs; v.valid = valid;
        v.a0 = a0; v.s0 = s0; v.t0 = t0;
        v.a1 = a1; v.s1 = s1; v.t1 = t1;
        v.rr = rr; v.e_ready = e_ready; v.e_v = e_v; v.e_r = e_r; v.e_id = e_id;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rs;
        bus.req_valid  = v.valid;
        bus.req_a      = {v.a1, v.a0};
        bus.req_shamt  = {v.s1, v.s0};
        bus.req_typ    = {v.t1, v.t0};
        bus.resp_ready = v.rr;
    endtask

    int accepts;
    int results;
    int budget;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a = 64'h0;
        bus.req_shamt = 10'h0;
        bus.req_typ = 4'h0;
        bus.resp_ready = 1'b0;

        //                rs    valid  a0            s0     t0     a1            s1     t1     rr    e_ready e_v   e_r           e_id
        vecs.push_back(mk(1'b1, 2'b01, 32'h8000_00F0, 5'd4, 2'b10, 32'h0,         5'd0,  2'b00, 1'b1, 2'b00, 1'b0, 32'h0000_0000, 1'b0)); // 0 reset, request ignored
        vecs.push_back(mk(1'b0, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b00, 1'b0, 32'h0,         1'b0)); // 1
        vecs.push_back(mk(1'b0, 2'b01, 32'h8000_00F0, 5'd4, 2'b10, 32'h0,         5'd0,  2'b00, 1'b1, 2'b01, 1'b0, 32'h0,         1'b0)); // 2 single op
        vecs.push_back(mk(1'b0, 2'b01, 32'h1234_5678, 5'd8, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b01, 1'b1, 32'hF800_000F, 1'b0)); // 3
        vecs.push_back(mk(1'b0, 2'b01, 32'h1234_5678, 5'd8, 2'b01, 32'h0,         5'd0,  2'b00, 1'b1, 2'b01, 1'b1, 32'h3456_7800, 1'b0)); // 4
        vecs.push_back(mk(1'b0, 2'b01, 32'h1234_5678, 5'd8, 2'b11, 32'h0,         5'd0,  2'b00, 1'b1, 2'b01, 1'b1, 32'h0012_3456, 1'b0)); // 5
        vecs.push_back(mk(1'b0, 2'b01, 32'h1234_5678, 5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b01, 1'b1, 32'h0000_1234, 1'b0)); // 6
        vecs.push_back(mk(1'b0, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b00, 1'b1, 32'h1234_5678, 1'b0)); // 7
        vecs.push_back(mk(1'b0, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b00, 1'b0, 32'h0,         1'b0)); // 8
        vecs.push_back(mk(1'b1, 2'b11, 32'h1,         5'd1, 2'b00, 32'h8000_0000, 5'd1,  2'b01, 1'b1, 2'b00, 1'b0, 32'h0,         1'b0)); // 9 reset with both valid
        vecs.push_back(mk(1'b0, 2'b11, 32'h1,         5'd1, 2'b00, 32'h8000_0000, 5'd1,  2'b01, 1'b1, 2'b01, 1'b0, 32'h0,         1'b0)); // 10 contention
        vecs.push_back(mk(1'b0, 2'b11, 32'h1,         5'd1, 2'b00, 32'h8000_0000, 5'd1,  2'b01, 1'b1, 2'b10, 1'b1, 32'h0000_0002, 1'b0)); // 11
        vecs.push_back(mk(1'b0, 2'b11, 32'h1,         5'd1, 2'b00, 32'h8000_0000, 5'd1,  2'b01, 1'b1, 2'b01, 1'b1, 32'h4000_0000, 1'b1)); // 12
        vecs.push_back(mk(1'b0, 2'b11, 32'h1,         5'd1, 2'b00, 32'h8000_0000, 5'd1,  2'b01, 1'b1, 2'b10, 1'b1, 32'h0000_0002, 1'b0)); // 13
        vecs.push_back(mk(1'b0, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b00, 1'b1, 32'h4000_0000, 1'b1)); // 14
        vecs.push_back(mk(1'b0, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b00, 1'b0, 32'h0,         1'b0)); // 15
        vecs.push_back(mk(1'b0, 2'b01, 32'h5,         5'd0, 2'b10, 32'h0,         5'd0,  2'b00, 1'b1, 2'b01, 1'b0, 32'h0,         1'b0)); // 16 sets prio=1
        vecs.push_back(mk(1'b0, 2'b10, 32'h0,         5'd0, 2'b00, 32'hFFFF_0000, 5'd4,  2'b10, 1'b1, 2'b10, 1'b1, 32'h0000_0005, 1'b0)); // 17 lone req1
        vecs.push_back(mk(1'b0, 2'b10, 32'h0,         5'd0, 2'b00, 32'hFFFF_0000, 5'd4,  2'b10, 1'b1, 2'b10, 1'b1, 32'hFFFF_F000, 1'b1)); // 18
        vecs.push_back(mk(1'b0, 2'b10, 32'h0,         5'd0, 2'b00, 32'hFFFF_0000, 5'd4,  2'b10, 1'b1, 2'b10, 1'b1, 32'hFFFF_F000, 1'b1)); // 19
        vecs.push_back(mk(1'b0, 2'b10, 32'h0,         5'd0, 2'b00, 32'hFFFF_0000, 5'd4,  2'b10, 1'b1, 2'b10, 1'b1, 32'hFFFF_F000, 1'b1)); // 20
        vecs.push_back(mk(1'b0, 2'b10, 32'h0,         5'd0, 2'b00, 32'hFFFF_0000, 5'd4,  2'b10, 1'b1, 2'b10, 1'b1, 32'hFFFF_F000, 1'b1)); // 21
        vecs.push_back(mk(1'b0, 2'b11, 32'h3,         5'd2, 2'b00, 32'h3,         5'd2,  2'b00, 1'b1, 2'b01, 1'b1, 32'hFFFF_F000, 1'b1)); // 22 prio back at 0
        vecs.push_back(mk(1'b0, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b00, 1'b1, 32'h0000_000C, 1'b0)); // 23
        vecs.push_back(mk(1'b0, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b00, 1'b0, 32'h0,         1'b0)); // 24
        vecs.push_back(mk(1'b0, 2'b01, 32'h0000_00FF, 5'd4, 2'b01, 32'h0,         5'd0,  2'b00, 1'b1, 2'b01, 1'b0, 32'h0,         1'b0)); // 25 backpressure
        vecs.push_back(mk(1'b0, 2'b10, 32'h0,         5'd0, 2'b00, 32'h1,         5'd31, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_000F, 1'b0)); // 26
        vecs.push_back(mk(1'b0, 2'b10, 32'h0,         5'd0, 2'b00, 32'h1,         5'd31, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_000F, 1'b0)); // 27
        vecs.push_back(mk(1'b0, 2'b10, 32'h0,         5'd0, 2'b00, 32'h1,         5'd31, 2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_000F, 1'b0)); // 28
        vecs.push_back(mk(1'b0, 2'b10, 32'h0,         5'd0, 2'b00, 32'h1,         5'd31, 2'b00, 1'b1, 2'b10, 1'b1, 32'h0000_000F, 1'b0)); // 29 drain+accept
        vecs.push_back(mk(1'b0, 2'b01, 32'hABCD_0000, 5'd7, 2'b11, 32'h0,         5'd0,  2'b00, 1'b1, 2'b01, 1'b1, 32'h8000_0000, 1'b1)); // 30
        vecs.push_back(mk(1'b0, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_ABCD, 1'b0)); // 31 held
        vecs.push_back(mk(1'b1, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b0, 2'b00, 1'b1, 32'h0000_ABCD, 1'b0)); // 32 reset pulse
        vecs.push_back(mk(1'b0, 2'b11, 32'h7,         5'd1, 2'b00, 32'h1,         5'd0,  2'b00, 1'b1, 2'b01, 1'b0, 32'h0,         1'b0)); // 33 old result gone
        vecs.push_back(mk(1'b0, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b00, 1'b1, 32'h0000_000E, 1'b0)); // 34
        vecs.push_back(mk(1'b0, 2'b00, 32'h0,         5'd0, 2'b00, 32'h0,         5'd0,  2'b00, 1'b1, 2'b00, 1'b0, 32'h0,         1'b0)); // 35

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            drive(vecs[i]);
            @(negedge clk);
            chk("req_ready", i, {30'd0, bus.req_ready}, {30'd0, vecs[i].e_ready});
            chk("resp_valid", i, {31'd0, bus.resp_valid}, {31'd0, vecs[i].e_v});
            if (vecs[i].e_v) begin
                chk("resp_r", i, bus.resp_r, vecs[i].e_r);
                chk("resp_id", i, {31'd0, bus.resp_id}, {31'd0, vecs[i].e_id});
            end
            @(posedge clk);
        end

        // Sustained single-requester stream: six accepts must yield six results back to back.
        accepts = 0;
        results = 0;
        #1;
        bus.req_valid  = 2'b10;
        bus.req_a      = {32'h0000_0100, 32'h0};
        bus.req_shamt  = {5'd8, 5'd0};
        bus.req_typ    = {2'b01, 2'b00};
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.req_ready == 2'b10) accepts++;
            if (bus.resp_valid) begin
                results++;
                chk("stream_r", 100 + c, bus.resp_r, 32'h0000_0001);
            end
            @(posedge clk);
        end
        #1;
        bus.req_valid = 2'b00;
        budget = 0;
        while (results < 6 && budget < 10) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                results++;
                chk("stream_r", 200 + budget, bus.resp_r, 32'h0000_0001);
            end
            budget++;
            @(posedge clk);
        end
        chk("stream_accepts", 300, accepts, 32'd6);
        chk("stream_results", 301, results, 32'd6);
        chk("stream_no_bubble", 302, budget, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
